// File: rtl/rsa_pkg.sv
// Shared RSA mode codes, controller state encoding and width default.
package rsa_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [1:0] RSA_MODE_ENC = 2'b10;
    localparam logic [1:0] RSA_MODE_DEC = 2'b01;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SQR  = 3'd2;
    localparam logic [2:0] S_SQW  = 3'd3;
    localparam logic [2:0] S_MUL  = 3'd4;
    localparam logic [2:0] S_MLW  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    function automatic logic mode_ok(input logic [1:0] m);
        return (m == RSA_MODE_ENC) || (m == RSA_MODE_DEC);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: P = A*B mod N, one bit of B
// per cycle MSB first; mm_done is high exactly W+1 cycles after mm_start.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mm_start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] N,
    output logic [W-1:0] P,
    output logic         mm_done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_r, b_r, n_r, p_r;
    logic [CW-1:0] cnt;
    logic          run;

    logic [W+1:0]  n_ext, sum, s1;
    logic [W-1:0]  s2;

    // 2P + A < 3N, so two conditional subtractions fully reduce
    always_comb begin
        n_ext = {2'b00, n_r};
        sum   = {1'b0, p_r, 1'b0} + (b_r[W-1] ? {2'b00, a_r} : '0);
        s1    = (sum >= n_ext) ? sum - n_ext : sum;
        s2    = (s1 >= n_ext) ? W'(s1 - n_ext) : s1[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
            p_r <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (mm_start) begin
            a_r <= A;
            b_r <= B;
            n_r <= N;
            p_r <= '0;
            cnt <= CW'(W);
            run <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                p_r <= s2;
                b_r <= b_r << 1;
                cnt <= cnt - 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign P       = p_r;
    assign mm_done = run && (cnt == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Constant-time left-to-right square-and-multiply controller for RSA
// encrypt/decrypt; the modular multiply runs for every exponent bit.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   E_D,
    input  logic         start,
    input  logic [W-1:0] msg_in,
    input  logic [W-1:0] exp_e,
    input  logic [W-1:0] exp_d,
    input  logic [W-1:0] n_mod,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int IW = $clog2(W);

    logic [2:0]    state;
    logic [1:0]    mode_r;
    logic [W-1:0]  msg_r, n_r, exp_r, r_r;
    logic [IW-1:0] idx;
    logic          invalid;

    logic          mm_start, mm_done;
    logic [W-1:0]  mm_b, mm_p;

    assign invalid  = !mode_ok(mode_r) || (n_r[W-1:1] == '0) || (msg_r >= n_r);
    assign mm_start = (state == S_SQR) || (state == S_MUL);
    assign mm_b     = (state == S_SQR) ? r_r : msg_r;

    // A rejected request never shows busy, only the err pulse
    assign busy = (state != S_IDLE) && !((state == S_LOAD) && invalid);

    rsa_modmul #(.W(W)) u_modmul (
        .clk      (clk),
        .rst      (rst),
        .mm_start (mm_start),
        .A        (r_r),
        .B        (mm_b),
        .N        (n_r),
        .P        (mm_p),
        .mm_done  (mm_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_r <= '0;
            msg_r  <= '0;
            n_r    <= '0;
            exp_r  <= '0;
            r_r    <= '0;
            idx    <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r <= E_D;
                        msg_r  <= msg_in;
                        n_r    <= n_mod;
                        exp_r  <= (E_D == RSA_MODE_ENC) ? exp_e : exp_d;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (invalid) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        r_r   <= W'(1);
                        idx   <= IW'(W - 1);
                        state <= S_SQR;
                    end
                end
                S_SQR: state <= S_SQW;
                S_SQW: begin
                    if (mm_done) begin
                        r_r   <= mm_p;
                        state <= S_MUL;
                    end
                end
                S_MUL: state <= S_MLW;
                S_MLW: begin
                    if (mm_done) begin
                        if (exp_r[idx]) r_r <= mm_p;
                        if (idx == '0) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= S_SQR;
                        end
                    end
                end
                S_FIN: begin
                    result <= r_r;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl: vector table, random ops
// against a right-to-left modexp model, and mid-run corner sequences.
module tb_rsa_modexp_ctrl;
    import rsa_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 2 + 2 * W * (W + 2);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   E_D = '0;
    logic         start = 1'b0;
    logic [W-1:0] msg_in = '0, exp_e = '0, exp_d = '0, n_mod = '0;
    logic [W-1:0] result;
    logic         busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_res = '0;

    always #5 clk = ~clk;

    rsa_modexp_ctrl #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .E_D    (E_D),
        .start  (start),
        .msg_in (msg_in),
        .exp_e  (exp_e),
        .exp_d  (exp_d),
        .n_mod  (n_mod),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] msg, e, d, n;
        logic         bad;
        logic [W-1:0] res;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m,
                                                 input logic [W-1:0] e,
                                                 input logic [W-1:0] n);
        longint r = 1;
        longint b = longint'(m) % longint'(n);
        longint x = longint'(e);
        while (x != 0) begin
            if (x % 2 == 1) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
            x = x / 2;
        end
        return W'(r % longint'(n));
    endfunction

    function automatic logic ref_bad(input logic [1:0] mode,
                                     input logic [W-1:0] m,
                                     input logic [W-1:0] n);
        return !(mode == 2'b10 || mode == 2'b01) || (n < 2) || (m >= n);
    endfunction

    task automatic launch(input logic [1:0] mode, input logic [W-1:0] m,
                          input logic [W-1:0] e, input logic [W-1:0] d,
                          input logic [W-1:0] n);
        @(negedge clk);
        E_D    = mode;
        msg_in = m;
        exp_e  = e;
        exp_d  = d;
        n_mod  = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input logic bad, input logic [W-1:0] exp_res,
                            input string nm);
        int k = 0;
        bit ended = 0;
        chk({nm, " busy_after_accept"}, longint'(busy), longint'(!bad));
        while (!ended && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
            if (done || err) ended = 1;
        end
        chk({nm, " latency"}, k, bad ? 1 : LAT);
        chk({nm, " err"}, longint'(err), longint'(bad));
        chk({nm, " done"}, longint'(done), longint'(!bad));
        chk({nm, " busy_at_end"}, longint'(busy), 0);
        chk({nm, " result"}, longint'(result), longint'(exp_res));
        prev_res = exp_res;
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [W-1:0] m,
                          input logic [W-1:0] e, input logic [W-1:0] d,
                          input logic [W-1:0] n, input logic bad,
                          input logic [W-1:0] res, input string nm);
        launch(mode, m, e, d, n);
        wait_end(bad, bad ? prev_res : res, nm);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int k, ndone, first_k;
        logic [W-1:0] res_at_done;

        tbl[0]  = '{2'b10, 16'd4,     16'd7,     16'd0, 16'd33,    1'b0, 16'd16};
        tbl[1]  = '{2'b01, 16'd16,    16'd9,     16'd3, 16'd33,    1'b0, 16'd4};
        tbl[2]  = '{2'b11, 16'd4,     16'd7,     16'd3, 16'd33,    1'b1, 16'd0};
        tbl[3]  = '{2'b00, 16'd4,     16'd7,     16'd3, 16'd33,    1'b1, 16'd0};
        tbl[4]  = '{2'b10, 16'd40,    16'd7,     16'd3, 16'd33,    1'b1, 16'd0};
        tbl[5]  = '{2'b10, 16'd0,     16'd7,     16'd3, 16'd1,     1'b1, 16'd0};
        tbl[6]  = '{2'b10, 16'd5,     16'd0,     16'd7, 16'd33,    1'b0, 16'd1};
        tbl[7]  = '{2'b01, 16'd2,     16'd0,     16'd7, 16'd33,    1'b0, 16'd29};
        tbl[8]  = '{2'b10, 16'd65534, 16'd65535, 16'd1, 16'd65535, 1'b0, 16'd65534};
        tbl[9]  = '{2'b10, 16'd33,    16'd7,     16'd3, 16'd33,    1'b1, 16'd0};
        tbl[10] = '{2'b01, 16'd1,     16'd9,     16'd5, 16'd2,     1'b0, 16'd1};
        tbl[11] = '{2'b10, 16'd0,     16'd5,     16'd3, 16'd0,     1'b1, 16'd0};

        #12;
        chk("reset result", longint'(result), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        chk("reset err", longint'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].mode, tbl[i].msg, tbl[i].e, tbl[i].d, tbl[i].n,
                   tbl[i].bad, tbl[i].res, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            logic [1:0]   mode;
            logic [W-1:0] m, e, d, n;
            int           r;
            logic         bad;
            r = int'($urandom_range(0, 7));
            mode = (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : ((r == 6) ? 2'b00 : 2'b11);
            n = W'($urandom_range(65535, 2));
            m = W'($urandom % n);
            if ($urandom_range(0, 9) == 0) m = W'($urandom_range(65535, n));
            e = W'($urandom);
            d = W'($urandom);
            bad = ref_bad(mode, m, n);
            run_op(mode, m, e, d, n, bad,
                   bad ? prev_res : ref_modexp(m, (mode == 2'b10) ? e : d, n),
                   $sformatf("rnd%0d", i));
        end

        // Disturb inputs and re-pulse start during a run
        launch(2'b10, 16'd4, 16'd7, 16'd0, 16'd33);
        k = 0;
        ndone = 0;
        first_k = 0;
        res_at_done = '0;
        while (k < 620) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                ndone++;
                if (first_k == 0) begin
                    first_k = k;
                    res_at_done = result;
                end
            end
            if (k == 100) begin
                E_D = 2'b01; msg_in = 16'd7; exp_e = 16'd3;
                exp_d = 16'd5; n_mod = 16'd99; start = 1'b1;
            end
            if (k == 101) start = 1'b0;
            if (k == 300) begin E_D = 2'b00; start = 1'b1; end
            if (k == 301) start = 1'b0;
        end
        chk("midrun latency", first_k, LAT);
        chk("midrun done_count", ndone, 1);
        chk("midrun result", longint'(res_at_done), 16);
        prev_res = 16'd16;

        // Reset in the middle of a run
        launch(2'b10, 16'd4, 16'd7, 16'd0, 16'd33);
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset result", longint'(result), 0);
        chk("midreset busy", longint'(busy), 0);
        chk("midreset done", longint'(done), 0);
        chk("midreset err", longint'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0;
        ndone = 0;
        for (int j = 0; j < 600; j++) begin
            @(posedge clk);
            #1;
            if (done || err) ndone++;
        end
        chk("after_reset no_pulse", ndone, 0);
        chk("after_reset result", longint'(result), 0);
        run_op(2'b01, 16'd16, 16'd9, 16'd3, 16'd33, 1'b0, 16'd4, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
